// File: rtl/sequential_divider.sv
// Sequential signed divider.
// Works on operand magnitudes with a restoring shift-subtract loop that
// produces one quotient bit per enabled cycle. A final fix-up cycle applies
// the signs and handles the divide-by-zero case.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } stateType;

  stateType         state_q;
  logic [CNT_W-1:0] cnt_q;

  // The accumulator is one bit wider than the operands so that a trial
  // subtraction of the shifted partial remainder shows its borrow in the
  // top bit without losing the carry-out of the shift.
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] quoShift_q;
  logic [WIDTH-1:0] divMag_q;
  logic [WIDTH-1:0] dividend_q;
  logic             divisorNeg_q;
  logic             divZero_q;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             divByZero_q;

  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH:0]   trialAcc;
  logic [WIDTH:0]   trialDiff;
  logic             borrow;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] quoShift_d;
  logic             negQuo;
  logic             negRem;
  logic [WIDTH-1:0] fixQuo_d;
  logic [WIDTH-1:0] fixRem_d;

  // Datapath for one restoring iteration plus the sign fix-up values.
  // The dividend magnitude sits in quoShift_q and is shifted out MSB first
  // while quotient bits are shifted in from the bottom. The most negative
  // dividend negates to itself, which is still the right unsigned magnitude.
  always_comb begin
    dividendMag = dividend[WIDTH-1] ? -dividend : dividend;
    divisorMag  = divisor[WIDTH-1]  ? -divisor  : divisor;

    trialAcc   = (acc_q << 1) | {{WIDTH{1'b0}}, quoShift_q[WIDTH-1]};
    trialDiff  = trialAcc - {1'b0, divMag_q};
    borrow     = trialDiff[WIDTH];
    acc_d      = borrow ? trialAcc : trialDiff;
    quoShift_d = {quoShift_q[WIDTH-2:0], ~borrow};

    negQuo   = dividend_q[WIDTH-1] ^ divisorNeg_q;
    negRem   = dividend_q[WIDTH-1];
    fixQuo_d = negQuo ? -quoShift_q : quoShift_q;
    fixRem_d = negRem ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (divZero_q) begin
      fixQuo_d = '1;
      fixRem_d = dividend_q;
    end
  end

  // Control FSM with registered busy/done and the result registers.
  // Nothing moves while en is low, so each stalled cycle adds exactly one
  // cycle of latency; reset wins over everything including en and start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      quoShift_q   <= '0;
      divMag_q     <= '0;
      dividend_q   <= '0;
      divisorNeg_q <= 1'b0;
      divZero_q    <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      divByZero_q  <= 1'b0;
    end else if (en) begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            dividend_q   <= dividend;
            divisorNeg_q <= divisor[WIDTH-1];
            divZero_q    <= (divisor == '0);
            divMag_q     <= divisorMag;
            quoShift_q   <= dividendMag;
            acc_q        <= '0;
            cnt_q        <= CNT_LOAD;
            busy_q       <= 1'b1;
            state_q      <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q      <= acc_d;
          quoShift_q <= quoShift_d;
          cnt_q      <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient_q  <= fixQuo_d;
          remainder_q <= fixRem_d;
          divByZero_q <= divZero_q;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = divByZero_q;

endmodule
